mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have this parameter: RAM_LAT, 1, RAM read latency in cycles, legal range 1..3.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd_req  in  1  level request, processor LDR read.
- cpu_wr_req  in  1  level request, processor STR write.
- cpu_addr  in  10  processor RAM address.
- cpu_wdata  in  10  processor write data.
- cpu_rdata  out  10  registered read data to the processor.
- cpu_done  out  1  one-cycle completion pulse, processor port.
- cpu_stall  out  1  holds the processor timestep counter.
- ext_req  in  1  level request, external program loader.
- ext_we  in  1  loader direction: 1 = write, 0 = read.
- ext_addr  in  10  loader address.
- ext_wdata  in  10  loader write data.
- ext_rdata  out  10  registered read data to the loader.
- ext_done  out  1  one-cycle completion pulse, loader port.
- ram_addr  out  10  single-port RAM address.
- ram_wdata  out  10  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  10  RAM read data, valid RAM_LAT cycles after the cycle in which ram_re is high.

Function
REQ-003 The state machine SHALL have four states: IDLE, ACCESS, WAIT and DONE; an "owner" register SHALL record the granted port.
REQ-004 In IDLE with at least one request high, the block SHALL grant one port and go to ACCESS on the next edge.
REQ-005 When both ports request in the same IDLE cycle, the port that was not granted last SHALL win; last_grant SHALL be EXT after reset, so the CPU wins the first tie.
REQ-006 At the grant edge, the address, write data and direction SHALL be latched; input changes after that edge SHALL be ignored until the next grant.
REQ-007 If cpu_rd_req and cpu_wr_req are both high, the transaction SHALL be a read and the write SHALL be discarded.
REQ-008 In ACCESS, for exactly one cycle, the block SHALL drive ram_addr and ram_wdata from the latched values and SHALL assert exactly one of ram_re or ram_we.
REQ-009 A write SHALL go from ACCESS to DONE; a read SHALL go from ACCESS to WAIT, stay in WAIT for RAM_LAT cycles, then go to DONE.
REQ-010 Timing from a request sampled in IDLE cycle N:
- read: DONE in cycle N+2+RAM_LAT;
- write: DONE in cycle N+2.
REQ-011 On the edge that leaves the last WAIT cycle, ram_rdata SHALL be captured into cpu_rdata or ext_rdata (owner only); the other port's rdata SHALL hold its value.
REQ-012 In DONE, the owner's done output SHALL be high for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-013 A requester SHALL drop its request on the edge that ends its done pulse; a request still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-014 A request withdrawn mid-transaction SHALL NOT abort it; the access and the done pulse SHALL still occur.
REQ-015 cpu_stall SHALL be combinational: (cpu_rd_req OR cpu_wr_req) AND NOT (state = DONE AND owner = CPU).
REQ-016 Addresses SHALL cover the full range 0..1023 with no bounds checking or wrap logic; address 1023 SHALL be accessed like any other.
REQ-017 ram_re and ram_we SHALL never be high together and SHALL be low in every state other than ACCESS.

Reset
REQ-018 While rst_n is low, regardless of clk, the block SHALL hold: state IDLE; ram_we, ram_re, cpu_done and ext_done at 0; ram_addr, ram_wdata, cpu_rdata and ext_rdata at 10'h000; last_grant EXT.
REQ-019 Reset asserted mid-transaction SHALL abort the transaction with no done pulse and no further RAM strobe; cpu_stall SHALL still follow REQ-015.
REQ-020 After rst_n deasserts, the first grant SHALL be possible in the first IDLE cycle.

Verification
REQ-021 RAM_LAT=1; CPU write 10'h2A5 to address 10'h3FF, then CPU read of 10'h3FF -> write done at N+2; read done at N+3 with cpu_rdata=10'h2A5.
REQ-022 CPU read and loader read raised in the same IDLE cycle after reset -> CPU is served first, then the loader; done pulses do not overlap; the grant order then alternates while both stay high.
REQ-023 RAM_LAT=3; loader read of address 10'h010 holding 10'h155 -> ext_done at N+5; ext_rdata=10'h155; cpu_rdata unchanged.
REQ-024 cpu_rd_req and cpu_wr_req both high, address 10'h001 -> only ram_re pulses, ram_we stays 0, RAM contents unchanged.
REQ-025 rst_n pulled low during WAIT -> all strobes and dones drop immediately; no done pulse; state IDLE after release.
REQ-026 CPU request withdrawn during ACCESS -> the write still commits, cpu_done still pulses, and cpu_stall is 0 from the withdrawal onward.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM: processor (CPU) and program loader (EXT).
// Ties between the ports alternate; one access in flight at a time, with a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_rd_req,
    input  logic       cpu_wr_req,
    input  logic [9:0] cpu_addr,
    input  logic [9:0] cpu_wdata,
    output logic [9:0] cpu_rdata,
    output logic       cpu_done,
    output logic       cpu_stall,
    input  logic       ext_req,
    input  logic       ext_we,
    input  logic [9:0] ext_addr,
    input  logic [9:0] ext_wdata,
    output logic [9:0] ext_rdata,
    output logic       ext_done,
    output logic [9:0] ram_addr,
    output logic [9:0] ram_wdata,
    output logic       ram_we,
    output logic       ram_re,
    input  logic [9:0] ram_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [9:0] addr_q, addr_d;
    logic [9:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [9:0] cpu_rdata_q, cpu_rdata_d;
    logic [9:0] ext_rdata_q, ext_rdata_d;

    logic cpu_req;
    logic grant_ext;

    assign cpu_req = cpu_rd_req | cpu_wr_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        wait_cnt_d   = wait_cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        grant_ext    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || ext_req) begin
                    // EXT wins only when CPU is idle or CPU took the previous grant
                    grant_ext    = ext_req && (!cpu_req || (last_grant_q == OWN_CPU));
                    owner_d      = grant_ext ? OWN_EXT : OWN_CPU;
                    last_grant_d = owner_d;
                    if (grant_ext) begin
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                        we_d    = ext_we;
                    end else begin
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        we_d    = cpu_wr_req && !cpu_rd_req;
                    end
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                wait_cnt_d = 2'd0;
                state_d    = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == LAT_M1) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_EXT) ext_rdata_d = ram_rdata;
                    else                    cpu_rdata_d = ram_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_EXT;
            addr_q       <= 10'h000;
            wdata_q      <= 10'h000;
            we_q         <= 1'b0;
            wait_cnt_q   <= 2'd0;
            cpu_rdata_q  <= 10'h000;
            ext_rdata_q  <= 10'h000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    // Strobes and dones decode straight from state so reset kills them without waiting for a clock
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_re    = (state_q == S_ACCESS) && !we_q;
    assign ram_we    = (state_q == S_ACCESS) && we_q;
    assign cpu_done  = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign ext_done  = (state_q == S_DONE) && (owner_q == OWN_EXT);
    assign cpu_stall = cpu_req && !cpu_done;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-numbered transaction model predicts every
// output each cycle; directed scenarios pin the model with hand-computed values.
module tb_mem_port_arbiter;

    localparam int RAM_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_rd_req = 1'b0, cpu_wr_req = 1'b0;
    logic [9:0] cpu_addr = '0, cpu_wdata = '0;
    logic [9:0] cpu_rdata;
    logic       cpu_done, cpu_stall;
    logic       ext_req = 1'b0, ext_we = 1'b0;
    logic [9:0] ext_addr = '0, ext_wdata = '0;
    logic [9:0] ext_rdata;
    logic       ext_done;
    logic [9:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_re;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_done(ext_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata)
    );

    // RAM behind the arbiter; read data appears RAM_LAT cycles after the strobe cycle
    logic [9:0] ram [1024];
    logic [9:0] rpipe [RAM_LAT];
    logic       pre_we = 1'b0;
    logic [9:0] pre_addr = '0, pre_data = '0;

    always @(posedge clk) begin
        if (pre_we)      ram[pre_addr] <= pre_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        rpipe[0] <= ram[ram_addr];
        for (int k = 1; k < RAM_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_rdata = rpipe[RAM_LAT-1];

    // Model: one transaction at a time, described by its grant cycle and completion cycle
    logic [9:0] mmem [1024];
    int         t = 0;
    bit         busy = 0, tx_ext = 0, tx_read = 0, last_ext = 1;
    int         tx_n = 0, tx_end = 0;
    logic [9:0] tx_addr = '0, tx_wdata = '0;
    logic [9:0] exp_crd = '0, exp_erd = '0;
    bit         m_done_c = 0, m_done_e = 0;
    bit         d_cpu = 0, d_ext = 0;
    int         cnt_we = 0, cnt_re = 0;
    int         checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    task automatic step();
        bit acc, dn, cr;
        @(negedge clk);
        t++;
        d_cpu = cpu_done;
        d_ext = ext_done;
        cnt_we += int'(ram_we);
        cnt_re += int'(ram_re);
        cr  = cpu_rd_req || cpu_wr_req;
        acc = 0;
        dn  = 0;
        if (!rst_n) begin
            busy = 0; last_ext = 1; exp_crd = '0; exp_erd = '0;
        end else begin
            if (busy && t > tx_end) busy = 0;
            acc = busy && (t == tx_n + 1);
            dn  = busy && (t == tx_end);
            if (dn && tx_read) begin
                if (tx_ext) exp_erd = mmem[tx_addr];
                else        exp_crd = mmem[tx_addr];
            end
        end
        chk("ram_re",    ram_re,    acc && tx_read);
        chk("ram_we",    ram_we,    acc && !tx_read);
        chk("cpu_done",  cpu_done,  dn && !tx_ext);
        chk("ext_done",  ext_done,  dn && tx_ext);
        chk("cpu_stall", cpu_stall, cr && !(dn && !tx_ext));
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("ext_rdata", ext_rdata, exp_erd);
        if (acc) begin
            chk("ram_addr",  ram_addr,  tx_addr);
            chk("ram_wdata", ram_wdata, tx_wdata);
        end else if (!rst_n) begin
            chk("rst_ram_addr",  ram_addr,  0);
            chk("rst_ram_wdata", ram_wdata, 0);
        end
        m_done_c = dn && !tx_ext;
        m_done_e = dn && tx_ext;
        if (rst_n) begin
            if (acc && !tx_read) mmem[tx_addr] = tx_wdata;
            if (!busy && (cr || ext_req)) begin
                tx_ext = ext_req && (!cr || !last_ext);
                if (tx_ext) begin
                    tx_read = !ext_we; tx_addr = ext_addr; tx_wdata = ext_wdata;
                end else begin
                    tx_read = cpu_rd_req; tx_addr = cpu_addr; tx_wdata = cpu_wdata;
                end
                busy     = 1;
                tx_n     = t;
                tx_end   = t + 2 + (tx_read ? RAM_LAT : 0);
                last_ext = tx_ext;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // lat = cycles from the first stepped cycle to the owner's done pulse; -1 on timeout
    task automatic wait_done(input bit ext, output int lat);
        int i;
        lat = -1;
        i = 0;
        while (lat < 0 && i < 40) begin
            step();
            if (ext ? d_ext : d_cpu) lat = i;
            i++;
        end
    endtask

    function automatic logic [9:0] rnd_addr();
        logic [9:0] a;
        case ($urandom_range(0, 3))
            0:       a = 10'h000;
            1:       a = 10'h3FF;
            default: a = 10'($urandom);
        endcase
        return a;
    endfunction

    task automatic rnd_cpu();
        case ($urandom_range(0, 2))
            0:       begin cpu_rd_req = 1; cpu_wr_req = 0; end
            1:       begin cpu_rd_req = 0; cpu_wr_req = 1; end
            default: begin cpu_rd_req = 1; cpu_wr_req = 1; end
        endcase
        cpu_addr  = rnd_addr();
        cpu_wdata = 10'($urandom);
    endtask

    task automatic rnd_ext();
        ext_req   = 1;
        ext_we    = 1'($urandom);
        ext_addr  = rnd_addr();
        ext_wdata = 10'($urandom);
    endtask

    int lat;
    int order [4];
    int exp_ord [4] = '{0, 1, 0, 1};
    int nd;
    bit ovl;
    bit c_wd, e_wd;

    initial begin
        // Preload RAM and model memory identically while reset is held
        for (int i = 0; i < 1024; i++) begin
            pre_addr = 10'(i);
            pre_data = (i == 16) ? 10'h155 : (i == 1) ? 10'h0AA : 10'($urandom);
            mmem[i]  = pre_data;
            pre_we   = 1;
            @(posedge clk);
            #1;
        end
        pre_we = 0;

        chk("rst_ram_re",    ram_re,    0);
        chk("rst_ram_we",    ram_we,    0);
        chk("rst_cpu_done",  cpu_done,  0);
        chk("rst_ext_done",  ext_done,  0);
        chk("rst_addr",      ram_addr,  0);
        chk("rst_wdata",     ram_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        chk("rst_stall",     cpu_stall, 0);
        rst_n = 1;

        // Tie straight after reset: CPU first, then strict alternation
        cpu_rd_req = 1; cpu_addr = 10'h100;
        ext_req = 1; ext_we = 0; ext_addr = 10'h101;
        nd = 0; ovl = 0;
        for (int i = 0; i < 80 && nd < 4; i++) begin
            step();
            if (d_cpu && d_ext) ovl = 1;
            if (d_cpu && nd < 4) begin order[nd] = 0; nd++; end
            else if (d_ext && nd < 4) begin order[nd] = 1; nd++; end
        end
        cpu_rd_req = 0; ext_req = 0;
        chk("tie_count", nd, 4);
        chk("tie_overlap", ovl, 0);
        for (int k = 0; k < 4; k++) chk("tie_order", order[k], exp_ord[k]);

        // CPU write then read of the top address
        cpu_wr_req = 1; cpu_addr = 10'h3FF; cpu_wdata = 10'h2A5;
        wait_done(0, lat);
        cpu_wr_req = 0;
        chk("wr_latency", lat, 2);
        chk("wr_mem", ram[10'h3FF], 10'h2A5);
        cpu_rd_req = 1;
        wait_done(0, lat);
        cpu_rd_req = 0;
        chk("rd_latency", lat, 2 + RAM_LAT);
        chk("rd_data", cpu_rdata, 10'h2A5);

        // Loader read; CPU read data must hold
        ext_req = 1; ext_we = 0; ext_addr = 10'h010;
        wait_done(1, lat);
        ext_req = 0;
        chk("ext_latency", lat, 2 + RAM_LAT);
        chk("ext_rdata_val", ext_rdata, 10'h155);
        chk("cpu_rdata_hold", cpu_rdata, 10'h2A5);

        // Read and write requested together: read only
        cpu_rd_req = 1; cpu_wr_req = 1; cpu_addr = 10'h001; cpu_wdata = 10'h3C3;
        cnt_we = 0; cnt_re = 0;
        wait_done(0, lat);
        cpu_rd_req = 0; cpu_wr_req = 0;
        chk("both_latency", lat, 2 + RAM_LAT);
        chk("both_re_cnt", cnt_re, 1);
        chk("both_we_cnt", cnt_we, 0);
        chk("both_mem", ram[10'h001], 10'h0AA);
        chk("both_rdata", cpu_rdata, 10'h0AA);

        // Write withdrawn during ACCESS still commits and pulses done
        cpu_wr_req = 1; cpu_addr = 10'h200; cpu_wdata = 10'h111;
        step();
        cpu_wr_req = 0;
        #1 chk("wd_stall", cpu_stall, 0);
        wait_done(0, lat);
        chk("wd_latency", lat, 1);
        chk("wd_mem", ram[10'h200], 10'h111);

        // Reset in the middle of a read's WAIT
        cpu_rd_req = 1; cpu_addr = 10'h3FF;
        step();
        step();
        rst_n = 0;
        #1;
        chk("mid_rst_re",    ram_re,    0);
        chk("mid_rst_we",    ram_we,    0);
        chk("mid_rst_done",  cpu_done,  0);
        chk("mid_rst_crd",   cpu_rdata, 0);
        chk("mid_rst_erd",   ext_rdata, 0);
        chk("mid_rst_stall", cpu_stall, 1);
        step();
        step();
        rst_n = 1;
        cpu_addr = 10'h010;
        wait_done(0, lat);
        cpu_rd_req = 0;
        chk("post_rst_latency", lat, 2 + RAM_LAT);
        chk("post_rst_data", cpu_rdata, 10'h155);

        // Random traffic: requests held until done, occasional repeats, withdrawals, input churn
        c_wd = 0; e_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_done_c) c_wd = 0;
            if ((cpu_rd_req || cpu_wr_req) && m_done_c) begin
                if ($urandom_range(0, 3) == 0) rnd_cpu();
                else begin cpu_rd_req = 0; cpu_wr_req = 0; end
            end else if (cpu_rd_req || cpu_wr_req) begin
                if (busy && !tx_ext && $urandom_range(0, 7) == 0) begin
                    cpu_rd_req = 0; cpu_wr_req = 0; c_wd = 1;
                end else if ($urandom_range(0, 1) == 1) rnd_cpu();
            end else if (!c_wd && $urandom_range(0, 2) == 0) rnd_cpu();

            if (m_done_e) e_wd = 0;
            if (ext_req && m_done_e) begin
                if ($urandom_range(0, 3) == 0) rnd_ext();
                else ext_req = 0;
            end else if (ext_req) begin
                if (busy && tx_ext && $urandom_range(0, 7) == 0) begin
                    ext_req = 0; e_wd = 1;
                end else if ($urandom_range(0, 1) == 1) rnd_ext();
            end else if (!e_wd && $urandom_range(0, 2) == 0) rnd_ext();

            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
